d_mem_reader: RTL and testbench

Initiator for the CPU's read-only 8-bit data memory, which returns data combinationally from an address. On `start` it walks a contiguous address range, wrapping modulo 256. It captures each byte into a 2-entry output buffer and streams the bytes out on a valid/ready interface, keeping a running 16-bit sum. It sits between the data memory and any consumer that needs bulk table reads, such as a display or UART path.

---
 rtl/d_mem_pkg.sv | 18 +
 rtl/d_mem_rd_fifo.sv | 49 ++++
 rtl/d_mem_reader.sv | 126 ++++++++++++
 tb/tb_d_mem_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/d_mem_pkg.sv
// rtl/d_mem_pkg.sv - shared widths, FSM states and buffer depth for the data-memory reader
package d_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/d_mem_rd_fifo.sv
// rtl/d_mem_rd_fifo.sv - 2-entry output buffer carrying {last, data}
module d_mem_rd_fifo
    import d_mem_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]      r_mem [0:FIFO_DEPTH-1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    // When full, push and pop hit the same slot; the head is read before the write lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/d_mem_reader.sv
// rtl/d_mem_reader.sv - walks a wrapping address range of the data memory and streams the bytes out
module d_mem_reader
    import d_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_length,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_sum
);

    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEFT = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [15:0]         r_sum;
    logic                r_busy;
    logic                r_done;

    logic [FIFO_CNT_W-1:0] w_count;
    logic [DATA_W:0]       w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_push;
    logic                  w_push_last;
    logic [ADDR_W:0]       w_len_clamped;

    assign w_valid       = (w_count != '0);
    assign w_pop         = w_valid && i_out_ready;
    assign w_push_ok     = (w_count < FIFO_FULL) || ((w_count == FIFO_FULL) && w_pop);
    assign w_push        = (r_state == ST_READ) && w_push_ok;
    assign w_push_last   = (r_remaining == ONE_LEFT);
    assign w_len_clamped = (i_length > MAX_LEN) ? MAX_LEN : i_length;

    d_mem_rd_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data ({w_push_last, i_mem_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_sum <= r_sum + 16'(w_head[DATA_W-1:0]);
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mem_addr  <= i_base;
                        r_remaining <= w_len_clamped;
                        r_sum       <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_push) begin
                        r_mem_addr  <= r_mem_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (w_push_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final byte carries the last flag, so its pop ends the transfer.
                    if (w_pop && w_head[DATA_W]) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_out_valid = w_valid;
    assign o_out_data  = w_head[DATA_W-1:0];
    assign o_out_last  = w_head[DATA_W];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_sum       = r_sum;

endmodule

// File: tb/tb_d_mem_reader.sv
// tb/tb_d_mem_reader.sv - table-driven bench for d_mem_reader against a small ROM model
module tb_d_mem_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = 8'd0;
    logic [8:0]  length = 9'd0;
    logic        out_ready = 1'b0;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    logic [7:0]  rom [0:7];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  length;
        bit          bp;
        int          poke;
        int          exp_n;
        logic [15:0] exp_sum;
        int          exp_done;
    } vec_t;

    vec_t vecs [0:6];

    always #5 clk = ~clk;

    assign mem_data = (mem_addr < 8'd8) ? rom[mem_addr[2:0]] : 8'd0;

    d_mem_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base      (base),
        .i_length    (length),
        .o_mem_addr  (mem_addr),
        .i_mem_data  (mem_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_busy      (busy),
        .o_done      (done),
        .o_sum       (sum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a);
        return (a < 8'd8) ? rom[a[2:0]] : 8'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum"}, sum, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc, n_hs, n_push, n_done, done_cyc, occ;
        logic [7:0] prev_addr, next_addr, byte_addr, held_data;
        logic       held_last, stalled;
        @(posedge clk); #1;
        base = v.base; length = v.length; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; n_hs = 0; n_push = 0; n_done = 0; done_cyc = -1;
        stalled = 1'b0; held_data = 8'd0; held_last = 1'b0; prev_addr = v.base;
        while (cyc < 700 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
            out_ready = v.bp ? (cyc % 2 == 1) : 1'b1;
            if (v.poke != 0 && cyc == v.poke) begin
                start = 1'b1; base = 8'd100; length = 9'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk("addr_first_cycle", mem_addr, v.base);
                chk("busy_first_cycle", busy, v.exp_n > 0);
            end
            if (mem_addr != prev_addr) begin
                next_addr = prev_addr + 8'd1;
                chk("addr_step", mem_addr, next_addr);
                n_push++;
            end
            prev_addr = mem_addr;
            occ = n_push - n_hs;
            chk("fifo_occupancy_le2", occ <= 2, 1);
            chk("out_valid", out_valid, occ > 0);
            if (stalled) begin
                chk("stall_data", out_data, held_data);
                chk("stall_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                byte_addr = v.base + n_hs[7:0];
                chk("byte", out_data, model(byte_addr));
                chk("last_flag", out_last, n_hs == v.exp_n - 1);
                n_hs++;
                stalled = 1'b0;
            end else begin
                stalled   = out_valid;
                held_data = out_data;
                held_last = out_last;
            end
            if (done) begin
                chk("busy_in_done", busy, 0);
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("done_count", n_done, 1);
        chk("done_cycle", done_cyc, v.exp_done);
        chk("handshakes", n_hs, v.exp_n);
        chk("pushes", n_push, v.exp_n);
        chk("sum", sum, v.exp_sum);
    endtask

    initial begin
        rom[0] = 8'd0; rom[1] = 8'd1; rom[2] = 8'd1; rom[3] = 8'd2;
        rom[4] = 8'd3; rom[5] = 8'd5; rom[6] = 8'd8; rom[7] = 8'd13;

        //           base    length   bp  poke  n    sum     done
        vecs[0] = '{8'd0,   9'd8,    0,  0,    8,   16'd33, 10};
        vecs[1] = '{8'd0,   9'd8,    1,  0,    8,   16'd33, 18};
        vecs[2] = '{8'd254, 9'd4,    0,  0,    4,   16'd1,  6};
        vecs[3] = '{8'd0,   9'd0,    0,  0,    0,   16'd0,  1};
        vecs[4] = '{8'd0,   9'd300,  0,  0,    256, 16'd33, 258};
        vecs[5] = '{8'd0,   9'd8,    0,  3,    8,   16'd33, 10};
        vecs[6] = '{8'd5,   9'd3,    0,  0,    3,   16'd26, 5};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort a full-table run after three accepted bytes.
        @(posedge clk); #1;
        base = 8'd0; length = 9'd8; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sum_before_abort", sum, 2);
        chk("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_during_reset", done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("done_after_release", done, 0);
        chk("valid_after_release", out_valid, 0);

        run_vec(vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
